// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the front-end stall/flush sequencer.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IMEM_WAIT = 2'd1,
        ERR       = 2'd2
    } fetch_ctrl_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Front-end stall/flush sequencer: redirects, load-use bubbles, IMEM wait tracking
// with timeout, and saturating stall/redirect performance counters.
module fetch_hazard_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_redirect_E,
    input  logic             i_mem_read_E,
    input  logic [4:0]       i_rd_E,
    input  logic [4:0]       i_rs1_D,
    input  logic [4:0]       i_rs2_D,
    input  logic             i_rs1_used_D,
    input  logic             i_rs2_used_D,
    input  logic             i_imem_ready,
    input  logic             i_cnt_clr,
    output logic             o_stall_F,
    output logic             o_stall_D,
    output logic             o_flush_D,
    output logic             o_flush_E,
    output logic             o_imem_err,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int unsigned    WaitW   = $clog2(TIMEOUT);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT - 1);

    fetch_ctrl_state_e state_q, state_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic              err_q, err_d;
    logic              load_use;

    assign load_use = i_mem_read_E && (i_rd_E != REG_X0) &&
                      ((i_rs1_used_D && (i_rs1_D == i_rd_E)) ||
                       (i_rs2_used_D && (i_rs2_D == i_rd_E)));

    always_comb begin
        o_stall_F = 1'b0;
        o_stall_D = 1'b0;
        o_flush_D = 1'b0;
        o_flush_E = 1'b0;
        state_d   = state_q;
        wait_d    = wait_q;
        err_d     = err_q;

        if (i_redirect_E) begin
            o_flush_D = 1'b1;
            o_flush_E = 1'b1;
            state_d   = RUN;
            wait_d    = '0;
        end else if (load_use) begin
            // Bubble into EX; a pending IMEM wait is frozen, not advanced.
            o_stall_F = 1'b1;
            o_stall_D = 1'b1;
            o_flush_E = 1'b1;
        end else if (state_q == ERR) begin
            o_stall_F = 1'b1;
            o_flush_D = 1'b1;
        end else if (!i_imem_ready) begin
            o_stall_F = 1'b1;
            o_flush_D = 1'b1;
            if (wait_q == WaitMax) begin
                state_d = ERR;
                err_d   = 1'b1;
            end else begin
                state_d = IMEM_WAIT;
                wait_d  = wait_q + 1'b1;
            end
        end else begin
            state_d = RUN;
            wait_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign o_state    = state_q;
    assign o_imem_err = err_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (o_stall_F),
        .i_clr   (i_cnt_clr),
        .o_count (o_stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (i_redirect_E),
        .i_clr   (i_cnt_clr),
        .o_count (o_flush_cnt)
    );

endmodule
